carpark_ctrl: RTL

CARPARK_CTRL -- requirements
Module: carpark_ctrl

---
 rtl/carpark_if.sv | 31 +++
 rtl/carpark_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/carpark_if.sv
// Car-park controller bus: entry sensors, password entry, exit sensor, and
// the controller's status outputs.
interface carpark_if #(
  parameter int PSWD_W = 4,
  parameter int CNT_W  = 4
);
  logic              fsensor;
  logic              bsensor;
  logic              pswd_valid;
  logic [PSWD_W-1:0] pswd;
  logic              exit_sensor;
  logic              gate_open;
  logic              pswd_ok;
  logic              pswd_err;
  logic              locked;
  logic              full;
  logic [CNT_W-1:0]  no_of_cars;
  logic [1:0]        state;

  // Driver side: the gate hardware and keypad.
  modport master (
    output fsensor, bsensor, pswd_valid, pswd, exit_sensor,
    input  gate_open, pswd_ok, pswd_err, locked, full, no_of_cars, state
  );

  // Controller side.
  modport slave (
    input  fsensor, bsensor, pswd_valid, pswd, exit_sensor,
    output gate_open, pswd_ok, pswd_err, locked, full, no_of_cars, state
  );
endinterface

// File: rtl/carpark_ctrl.sv
// Car-park entry controller: password-gated entry barrier with lockout after
// repeated wrong entries, idle timeouts, and an occupancy counter fed by
// entries and exit-sensor rising edges.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE   (0) | waiting for a car at the entry gate (ignored when full)
//   WAIT   (1) | car present, waiting for a password entry
//   OPEN   (2) | barrier raised, waiting for the car to pass
//   LOCKED (3) | too many wrong passwords, entry ignored for a while
module carpark_ctrl #(
  parameter int                CAPACITY    = 12,
  parameter int                CNT_W       = 4,
  parameter int                PSWD_W      = 4,
  parameter logic [PSWD_W-1:0] PSWD        = 4'b1010,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCK_CYCLES = 16,
  parameter int                TIMEOUT     = 32
) (
  input logic      clk,
  input logic      reset,
  carpark_if.slave bus
);

  // One timer serves both the idle timeouts and the lockout duration.
  localparam int TMR_MAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int TRY_W   = $clog2(MAX_TRIES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_OPEN   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [TRY_W-1:0] tries_q;
  logic             ok_q;
  logic             err_q;
  logic             exit_prev_q;
  logic [CNT_W-1:0] cars_q;
  logic [CNT_W-1:0] cars_d;

  logic full;
  logic entry;
  logic exit_ev;

  assign full    = (cars_q == CNT_W'(CAPACITY));
  assign entry   = (state_q == S_OPEN) && bus.bsensor;
  assign exit_ev = bus.exit_sensor && !exit_prev_q;

  // Entry FSM with its timer, try counter and the password result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tries_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.fsensor && !full) begin
            state_q <= S_WAIT;
            timer_q <= '0;
            tries_q <= '0;
          end
        end
        S_WAIT: begin
          if (bus.pswd_valid) begin
            timer_q <= '0;
            if (bus.pswd == PSWD) begin
              ok_q    <= 1'b1;
              tries_q <= '0;
              state_q <= S_OPEN;
            end else begin
              err_q   <= 1'b1;
              tries_q <= tries_q + 1'b1;
              if (tries_q == TRY_W'(MAX_TRIES - 1)) state_q <= S_LOCKED;
            end
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_OPEN: begin
          if (bus.bsensor || timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          // Try counter stays at its limit while locked so the cause is visible.
          if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            tries_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Occupancy next value: coincident entry and exit cancel out.
  always_comb begin
    cars_d = cars_q;
    if (entry && !exit_ev) begin
      if (!full) cars_d = cars_q + 1'b1;
    end else if (exit_ev && !entry) begin
      if (cars_q != '0) cars_d = cars_q - 1'b1;
    end
  end

  // Occupancy counter and exit-sensor edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      cars_q      <= '0;
      exit_prev_q <= 1'b0;
    end else begin
      cars_q      <= cars_d;
      exit_prev_q <= bus.exit_sensor;
    end
  end

  assign bus.gate_open  = (state_q == S_OPEN);
  assign bus.locked     = (state_q == S_LOCKED);
  assign bus.pswd_ok    = ok_q;
  assign bus.pswd_err   = err_q;
  assign bus.full       = full;
  assign bus.no_of_cars = cars_q;
  assign bus.state      = state_q;

endmodule
